// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes and FSM state encoding shared by the mult/div unit
package muldiv_pkg;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_COMMIT} state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: working registers with one shift-add / restoring-divide step per cycle
// Ports: i_load latches operands (i_div/i_signed select the op), i_step runs one iteration,
//   i_fix applies sign correction; o_hi/o_lo expose the working result {hi,lo};
//   o_mul_early flags that no multiplier bits remain (only with MULDIV_EARLY_EXIT_EN).
module muldiv_iter_core #(
  parameter int NB = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic          i_fix,
  input  logic          i_div,
  input  logic          i_signed,
  input  logic [NB-1:0] i_data_a,
  input  logic [NB-1:0] i_data_b,
  output logic [NB-1:0] o_hi,
  output logic [NB-1:0] o_lo,
  output logic          o_mul_early
);
  // acc holds the product, or {remainder, quotient} while dividing; mcand low half is the divisor
  logic [2*NB-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [NB-1:0] mplier_q, mplier_d, abs_a, abs_b;
  logic [NB:0] rem_sh, trial;
  logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  always_comb begin
    abs_a = (i_signed & i_data_a[NB-1]) ? -i_data_a : i_data_a;
    abs_b = (i_signed & i_data_b[NB-1]) ? -i_data_b : i_data_b;
    rem_sh = {acc_q[2*NB-1:NB], acc_q[NB-1]};
    trial = rem_sh - {1'b0, mcand_q[NB-1:0]};
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    div_d = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (i_load) begin
      div_d = i_div;
      neg_lo_d = i_signed & (i_data_a[NB-1] ^ i_data_b[NB-1]);
      neg_hi_d = i_signed & i_data_a[NB-1];
      mplier_d = abs_b;
      mcand_d = {{NB{1'b0}}, i_div ? abs_b : abs_a};
      acc_d = !i_div ? '0 : (i_data_b == '0) ? {i_data_a, {NB{1'b1}}} : {{NB{1'b0}}, abs_a};
    end else if (i_step) begin
      mplier_d = mplier_q >> 1;
      mcand_d = div_q ? mcand_q : mcand_q << 1;
      acc_d = !div_q ? acc_q + (mplier_q[0] ? mcand_q : '0)
            : trial[NB] ? {rem_sh[NB-1:0], acc_q[NB-2:0], 1'b0}
            : {trial[NB-1:0], acc_q[NB-2:0], 1'b1};
    end else if (i_fix) begin
      acc_d = !div_q ? (neg_lo_q ? -acc_q : acc_q)
            : {neg_hi_q ? -acc_q[2*NB-1:NB] : acc_q[2*NB-1:NB],
               neg_lo_q ? -acc_q[NB-1:0] : acc_q[NB-1:0]};
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      div_q <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end
  assign o_hi = acc_q[2*NB-1:NB];
  assign o_lo = acc_q[NB-1:0];
`ifdef MULDIV_EARLY_EXIT_EN
  // bit 0 is consumed by the current step, so only the bits above it matter
  assign o_mul_early = (mplier_q >> 1) == '0;
`else
  assign o_mul_early = 1'b0;
`endif
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall
// Ports: i_valid/i_funct_code/i_data_a/i_data_b from EX, i_flush aborts; o_hi/o_lo are the
//   architectural registers, o_stall freezes IF/ID/EX, o_busy = not idle, o_done/o_div_zero pulse
//   on commit. Define MULDIV_EARLY_EXIT_EN to stop multiplies once the multiplier runs out of ones.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int NB       = 32,
  parameter int NB_FCODE = 6,
  parameter int NB_CNT   = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [NB_FCODE-1:0] i_funct_code,
  input  logic                i_flush,
  input  logic [NB-1:0]       i_data_a,
  input  logic [NB-1:0]       i_data_b,
  output logic [NB-1:0]       o_hi,
  output logic [NB-1:0]       o_lo,
  output logic                o_stall,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_div_zero
);
  state_t state_q, state_d, mul_start;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [NB-1:0] hi_q, hi_d, lo_q, lo_d, core_hi, core_lo;
  logic done_q, done_d, dz_q, dz_d, dz_pend_q, dz_pend_d;
  logic is_md, unit, accept, is_div, b_zero, load, step, fix, mul_early;
  always_comb begin
    is_md = i_funct_code inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    unit = i_valid & (is_md | (i_funct_code inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO}));
    accept = unit & (state_q == ST_IDLE) & !i_flush;
    is_div = i_funct_code[1];
    b_zero = i_data_b == '0;
    o_busy = state_q != ST_IDLE;
    o_stall = unit & o_busy;
`ifdef MULDIV_EARLY_EXIT_EN
    mul_start = b_zero ? ST_FIX : ST_MUL;
`else
    mul_start = ST_MUL;
`endif
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    dz_pend_d = dz_pend_q;
    load = 1'b0;
    step = 1'b0;
    fix = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (is_md) begin
          load = 1'b1;
          cnt_d = NB_CNT'(NB);
          dz_pend_d = is_div & b_zero;
          state_d = !is_div ? mul_start : b_zero ? ST_COMMIT : ST_DIV;
        end
        hi_d = (i_funct_code == FUNCT_MTHI) ? i_data_a : hi_q;
        lo_d = (i_funct_code == FUNCT_MTLO) ? i_data_a : lo_q;
      end
      ST_MUL, ST_DIV: begin
        step = 1'b1;
        cnt_d = cnt_q - NB_CNT'(1);
        state_d = (cnt_q == NB_CNT'(1) || (state_q == ST_MUL && mul_early)) ? ST_FIX : state_q;
      end
      ST_FIX: begin
        fix = 1'b1;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        hi_d = core_hi;
        lo_d = core_lo;
        done_d = 1'b1;
        dz_d = dz_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d = '0;
      hi_d = hi_q;
      lo_d = lo_q;
      done_d = 1'b0;
      dz_d = 1'b0;
      step = 1'b0;
      fix = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      dz_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dz_q <= dz_d;
      dz_pend_q <= dz_pend_d;
    end
  end
  assign o_hi = hi_q;
  assign o_lo = lo_q;
  assign o_done = done_q;
  assign o_div_zero = dz_q;
  muldiv_iter_core #(.NB(NB)) u_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (load),
    .i_step     (step),
    .i_fix      (fix),
    .i_div      (is_div),
    .i_signed   (!i_funct_code[0]),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .o_hi       (core_hi),
    .o_lo       (core_lo),
    .o_mul_early(mul_early)
  );
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized + directed check of muldiv_sequencer against a cycle-count model
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  localparam int NB = 32;
  logic clk = 1'b0, rst_n = 1'b1, valid = 1'b0, flush = 1'b0;
  logic [5:0] funct = '0;
  logic [31:0] da = '0, db = '0;
  logic [31:0] o_hi, o_lo;
  logic o_stall, o_busy, o_done, o_div_zero;
  int n_vec = 0, n_mis = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int m_cnt = 0;
  bit chk_en = 1'b0;
  logic [5:0] ops [8] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                          FUNCT_MTHI, FUNCT_MTLO, FUNCT_MFHI, FUNCT_MFLO};

  muldiv_sequencer #(.NB(NB), .NB_FCODE(6), .NB_CNT(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_funct_code(funct), .i_flush(flush),
    .i_data_a(da), .i_data_b(db), .o_hi(o_hi), .o_lo(o_lo), .o_stall(o_stall),
    .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero)
  );

  always #5 clk = ~clk;

  function automatic bit is_md(logic [5:0] f);
    return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

  function automatic bit is_unit(logic [5:0] f);
    return is_md(f) || (f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
  endfunction

  function automatic int latency(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    logic [31:0] m;
    m = (f == FUNCT_MULT && b[31]) ? -b : b;
    if ((f == FUNCT_DIV || f == FUNCT_DIVU) && b == 0) return 1;
`ifdef MULDIV_EARLY_EXIT_EN
    if (f == FUNCT_MULT || f == FUNCT_MULTU) begin
      if (m == 0) return 2;
      for (int i = 31; i >= 0; i--) if (m[i]) return i + 3;
    end
`endif
    if (m == 32'hDEAD_BEEF) return NB + 2;
    return NB + 2;
  endfunction

  task automatic compute(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] p, q, r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p = '0;
    if (f == FUNCT_MULT) p = sa * sb;
    else if (f == FUNCT_MULTU) p = {32'b0, a} * {32'b0, b};
    else if (b == 0) begin p = {a, 32'hFFFF_FFFF}; dz = 1'b1; end
    else if (f == FUNCT_DIV) begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
    else p = {a % b, a / b};
    hi = p[63:32];
    lo = p[31:0];
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0; m_dz = 1'b0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    m_dz = 1'b0;
    if (flush) m_cnt = 0;
    else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz; end
    end else if (valid) begin
      if (is_md(funct)) begin
        compute(funct, da, db, p_hi, p_lo, p_dz);
        m_cnt = latency(funct, da, db);
      end else if (funct == FUNCT_MTHI) m_hi = da;
      else if (funct == FUNCT_MTLO) m_lo = da;
    end
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("hi", o_hi, m_hi);
      check("lo", o_lo, m_lo);
      check("busy", {31'b0, o_busy}, {31'b0, m_cnt > 0});
      check("done", {31'b0, o_done}, {31'b0, m_done});
      check("div_zero", {31'b0, o_div_zero}, {31'b0, m_dz});
      check("stall", {31'b0, o_stall}, {31'b0, valid && is_unit(funct) && m_cnt > 0});
    end
  end

  task automatic set_in(bit v, logic [5:0] f, logic [31:0] a, logic [31:0] b, bit fl);
    valid = v; funct = f; da = a; db = b; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic filler();
    case ($urandom_range(0, 4))
      0: set_in(1'b0, FUNCT_MULT, $urandom, $urandom, 1'b0);
      1: set_in(1'b1, FUNCT_MFHI, $urandom, $urandom, 1'b0);
      2: set_in(1'b1, FUNCT_MFLO, $urandom, $urandom, 1'b0);
      3: set_in(1'b1, 6'h20, $urandom, $urandom, 1'b0);
      default: set_in(1'b1, 6'h3F, $urandom, $urandom, 1'b0);
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic run_op(logic [5:0] f, logic [31:0] a, logic [31:0] b, int flush_at);
    set_in(1'b1, f, a, b, 1'b0);
    tick();
    for (int i = 1; i <= 60 && m_cnt > 0; i++) begin
      filler();
      if (i == flush_at) flush = 1'b1;
      tick();
    end
  endtask

  task automatic directed(string nm, logic [5:0] f, logic [31:0] a, logic [31:0] b,
                          logic [31:0] hi, logic [31:0] lo, bit dz);
    int lat;
    lat = 0;
    set_in(1'b1, f, a, b, 1'b0);
    tick();
    while (!o_done && lat < 60) begin
      set_in(1'b1, FUNCT_MFLO, 32'h0, 32'h0, 1'b0);
      #1;
      if (lat == 0 && latency(f, a, b) > 1) check({nm, "_stall"}, {31'b0, o_stall}, 32'h1);
      tick();
      lat++;
    end
    check({nm, "_lat"}, lat, latency(f, a, b));
    check({nm, "_hi"}, o_hi, hi);
    check({nm, "_lo"}, o_lo, lo);
    check({nm, "_dz"}, {31'b0, o_div_zero}, {31'b0, dz});
    set_in(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    int dn;
    logic [5:0] f;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_hi", o_hi, 32'h0);
    check("rst_lo", o_lo, 32'h0);
    check("rst_busy", {31'b0, o_busy}, 32'h0);
    check("rst_done", {31'b0, o_done}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    directed("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    directed("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    directed("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    directed("div_minint", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    directed("divu_zero", FUNCT_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    set_in(1'b1, FUNCT_MTHI, 32'hA5A5_A5A5, 32'h0, 1'b0);
    tick();
    set_in(1'b1, FUNCT_MULT, 32'd5, 32'd3, 1'b0);
    tick();
    for (int i = 1; i < 10; i++) begin
      set_in(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    set_in(1'b0, 6'h0, 32'h0, 32'h0, 1'b1);
    tick();
    check("flush_busy", {31'b0, o_busy}, 32'h0);
    set_in(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
    dn = 0;
    repeat (40) begin
      tick();
      dn += int'(o_done);
    end
    check("flush_no_done", dn, 0);
    check("flush_hi", o_hi, 32'hA5A5_A5A5);
    set_in(1'b1, FUNCT_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    set_in(1'b1, FUNCT_MFHI, 32'h0, 32'h0, 1'b0);
    repeat (10) tick();
    check("middiv_busy", {31'b0, o_busy}, 32'h1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_hi", o_hi, 32'h0);
    check("arst_lo", o_lo, 32'h0);
    check("arst_busy", {31'b0, o_busy}, 32'h0);
    check("arst_stall", {31'b0, o_stall}, 32'h0);
    check("arst_done", {31'b0, o_done | o_div_zero}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (90) begin
      f = ops[$urandom_range(0, 7)];
      run_op(f, pick(), pick(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 36)) : 0);
    end
    set_in(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit beside the EX-stage ALU.
- Owns the HI/LO architectural registers.
- Sequences iterative MULT/MULTU/DIV/DIVU, serves MTHI/MTLO/MFHI/MFLO, and stalls the pipeline while an operation is in flight.
- Decode/EX control provides funct code and operands; hazard control consumes o_stall.

Parameters:
- NB, 32, datapath width (HI/LO/operands)
- NB_FCODE, 6, funct code width
- NB_CNT, 6, iteration counter width (must hold NB)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  EX holds an instruction for this unit (funct qualified by opcode SPECIAL)
- i_funct_code  in  NB_FCODE  0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO
- i_flush  in  1  abort in-flight operation (pipeline flush / debug halt)
- i_data_a  in  NB  rs operand (dividend / multiplicand / MTHI-MTLO source)
- i_data_b  in  NB  rt operand (divisor / multiplier)
- o_hi  out  NB  HI register
- o_lo  out  NB  LO register
- o_stall  out  1  freeze IF/ID/EX
- o_busy  out  1  FSM not IDLE
- o_done  out  1  one-cycle pulse: HI/LO just committed by mult/div
- o_div_zero  out  1  one-cycle pulse with o_done on divide by zero

Behaviour:
- Reset: all outputs 0, HI=LO=0, FSM=IDLE, counter=0.
- States: IDLE, MUL, DIV, FIX, COMMIT.
- IDLE:
  - i_valid & MULT/MULTU: latch |a|, |b| (MULTU: raw), record result sign, clear the 2NB accumulator, counter=NB, go to MUL.
  - i_valid & DIV/DIVU with b≠0: latch magnitudes, remainder=0, go to DIV.
  - i_valid & DIV/DIVU with b=0: go to COMMIT directly with HI=a, LO=all ones, o_div_zero=1.
- MUL: one shift-add step per cycle; counter decrements; on counter=1 go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); on counter=1 go to FIX.
- FIX (signed ops only, else pass-through):
  - MULT: negate the 2NB product if signs differ.
  - DIV: quotient negated if a[NB-1]^b[NB-1]; remainder takes the sign of a.
  - MIN_INT/-1 gives LO=0x80000000, HI=0.
- COMMIT: write HI/LO from working registers, pulse o_done, return to IDLE.
- Latency: start edge to o_done = NB+2 cycles (34 at default); divide by zero = 1 cycle.
- HI/LO change only in COMMIT or on MTHI/MTLO; working registers are separate.
- MTHI/MTLO in IDLE: write at the next edge, no stall.
- MFHI/MFLO read o_hi/o_lo combinationally.
- o_stall = i_valid & (FSM≠IDLE):
  - any unit instruction (including MFHI/MFLO/MTHI/MTLO) waits until IDLE.
  - a new op is never accepted in the COMMIT cycle.
  - MFHI arriving in the COMMIT cycle stalls exactly once, then reads the new value.
- o_stall never depends on a non-unit instruction; non-unit instructions proceed while the unit is busy.
- Unknown funct with i_valid: ignored, no stall.
- i_flush: has priority over everything. In any busy state, return to IDLE at the next edge; HI/LO untouched; no o_done. In IDLE, suppresses acceptance that cycle.
- Reset mid-operation: asynchronous return to the reset state.

Optional Feature:
- MULDIV_EARLY_EXIT_EN
  - Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX immediately. Latency = (index of highest set bit of |b|)+3 cycles; b=0 gives 2 cycles.
  - Undefined: fixed NB+2 latency for all mult/div.
  - Results are identical either way.

Decomposition:
- Package muldiv_pkg:
  - funct constants FUNCT_MULT..FUNCT_MTLO
  - state encoding constants ST_IDLE..ST_COMMIT
- Sub-module muldiv_iter_core holds the working registers plus one-step shift-add/restore logic, driven by step/load/op-select from the FSM.
- The FSM, HI/LO and stall logic stay in muldiv_sequencer.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 → o_done at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_stall high for a following MFLO until then.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 → LO=0x80000000, HI=0.
- DIVU b=0, a=0x1234 → done after 1 cycle; o_div_zero=1; HI=0x1234, LO=0xFFFFFFFF.
- MTHI 0xA5A5A5A5, start MULT, assert i_flush at cycle 10 → o_busy drops next edge, no o_done, HI still 0xA5A5A5A5. Then assert i_rst_n low mid-DIV → all outputs 0 asynchronously.
